instr_fetch_unit: RTL and testbench



---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OPC_ALU = 2'b11;
  localparam logic [3:0] FN_HLT  = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} ifu_state_e;

  function automatic logic is_hlt(input logic [15:0] w);
    return (w[15:14] == OPC_ALU) && (w[7:4] == FN_HLT);
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Two-entry {instr, pc} buffer between the memory handshake and decode.
// Flush wins over push; pop of an empty buffer is ignored.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [15:0]       push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  output logic [15:0]       head_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CNT_W-1:0]  count
);
  logic [15:0]       mem_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !flush && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload needs no reset: it is only observed behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 2-deep buffer,
// PC_load redirect. Optional HLT detection under `IFU_HALT_DETECT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       COMMAND,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_pc,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              halted
);
  ifu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pc, req_pc;
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic              push, pop, hlt_hit;
  logic [15:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  assign push    = (state == WAIT) && imem_rvalid && !PC_load;
  assign pop     = cmd_valid && cmd_ready && !PC_load;
  assign cnt_nxt = PC_load ? '0 : count + CNT_W'(push) - CNT_W'(pop);

`ifdef IFU_HALT_DETECT_EN
  assign hlt_hit = push && is_hlt(imem_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       halted <= 1'b0;
    else if (PC_load) halted <= 1'b0;
    else if (hlt_hit) halted <= 1'b1;
  end
`else
  assign hlt_hit = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (PC_load)                  pc <= pc_target;
      else if (imem_req && imem_gnt) pc <= pc + ADDR_W'(1);
      if (imem_req && imem_gnt) req_pc <= pc;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (PC_load) state_nxt = REQ;
        else if ((cnt_nxt < CNT_W'(FIFO_DEPTH)) && !halted) state_nxt = REQ;
      end
      REQ: begin
        if (PC_load)       state_nxt = imem_gnt ? DROP : IDLE;
        else if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (PC_load)
          state_nxt = imem_rvalid ? REQ : DROP;
        else if (imem_rvalid)
          state_nxt = (hlt_hit || (cnt_nxt >= CNT_W'(FIFO_DEPTH))) ? IDLE : REQ;
      end
      DROP: begin
        // A redirect landing with the stale response has already drained it,
        // so waiting on in DROP would never see another rvalid.
        if (imem_rvalid) state_nxt = (halted && !PC_load) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == REQ);
  end

  assign imem_addr = pc;

  ifu_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (PC_load),
    .push_instr (imem_rdata),
    .push_pc    (req_pc),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  assign cmd_valid = (count != '0);
  assign COMMAND   = cmd_valid ? head_instr : 16'h0000;
  assign cmd_pc    = cmd_valid ? head_pc : pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a second instance checks PC wrap from 16'hFFFF.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] COMMAND, cmd_pc, pc_target;
  logic        cmd_valid, cmd_ready, PC_load, halted;

  logic        req2, rvalid2, cmd_valid2, halted2;
  logic [15:0] addr2, rdata2, cmd2, cmd_pc2;

  logic        gnt_en;
  int          rv_delay;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .COMMAND(COMMAND), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pc(cmd_pc),
    .PC_load(PC_load), .pc_target(pc_target), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(req2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .COMMAND(cmd2), .cmd_valid(cmd_valid2), .cmd_ready(1'b1), .cmd_pc(cmd_pc2),
    .PC_load(1'b0), .pc_target(16'h0000), .halted(halted2)
  );

  function automatic logic [15:0] word(input logic [15:0] a);
`ifdef IFU_HALT_DETECT_EN
    if (a == 16'd3) return 16'hC0F0;
`endif
    return {4'h1, a[11:0]};
  endfunction

  // Memory model: grant while gnt_en, data rv_delay cycles after the grant.
  logic        busy;
  int          cnt;
  logic [15:0] paddr;
  assign imem_gnt = imem_req && gnt_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 16'h0000;
      busy        <= 1'b0;
      cnt         <= 0;
      paddr       <= 16'h0000;
    end else begin
      imem_rvalid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= word(paddr);
          busy        <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (imem_req && imem_gnt) begin
        if (rv_delay <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= word(imem_addr);
        end else begin
          busy  <= 1'b1;
          cnt   <= rv_delay - 1;
          paddr <= imem_addr;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid2 <= 1'b0;
      rdata2  <= 16'h0000;
    end else begin
      rvalid2 <= req2;
      rdata2  <= word(addr2);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset held for two cycles, released on a falling edge; next rising edge is P1.
  task automatic do_reset(input logic ready);
    rst_n     = 1'b0;
    cmd_ready = ready;
    PC_load   = 1'b0;
    pc_target = 16'h0000;
    rv_delay  = 1;
    gnt_en    = 1'b1;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_ready = 1'b1; PC_load = 1'b0; pc_target = 16'h0000;
    rv_delay = 1; gnt_en = 1'b1;
    tick(2);
    chk("rst_req",       {15'd0, imem_req},  16'h0000);
    chk("rst_addr",      imem_addr,          16'h0000);
    chk("rst_valid",     {15'd0, cmd_valid}, 16'h0000);
    chk("rst_command",   COMMAND,            16'h0000);
    chk("rst_cmd_pc",    cmd_pc,             16'h0000);
    chk("rst_halted",    {15'd0, halted},    16'h0000);
    chk("rst_wrap_addr", addr2,              16'hFFFF);
    chk("rst_wrap_pc",   cmd_pc2,            16'hFFFF);
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready
    tick(1);
    chk("t1_p1_req",  {15'd0, imem_req},  16'h0001);
    chk("t1_p1_addr", imem_addr,          16'h0000);
    chk("t1_p1_vld",  {15'd0, cmd_valid}, 16'h0000);
    chk("wrap_p1_addr", addr2,            16'hFFFF);
    tick(1);
    chk("t1_p2_req",  {15'd0, imem_req},  16'h0000);
    chk("t1_p2_vld",  {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t1_p3_vld",  {15'd0, cmd_valid}, 16'h0001);
    chk("t1_p3_cmd",  COMMAND,            word(16'd0));
    chk("t1_p3_pc",   cmd_pc,             16'h0000);
    chk("t1_p3_addr", imem_addr,          16'h0001);
    chk("wrap_p3_req",  {15'd0, req2},    16'h0001);
    chk("wrap_p3_addr", addr2,            16'h0000);
    chk("wrap_p3_pc",   cmd_pc2,          16'hFFFF);
    chk("wrap_p3_cmd",  cmd2,             word(16'hFFFF));
    chk("wrap_halted",  {15'd0, halted2}, 16'h0000);
    tick(1);
    chk("t1_p4_vld",  {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t1_p5_cmd",  COMMAND,            word(16'd1));
    chk("t1_p5_pc",   cmd_pc,             16'h0001);
    chk("t1_p5_addr", imem_addr,          16'h0002);
    tick(2);
    chk("t1_p7_cmd",  COMMAND,            word(16'd2));
    chk("t1_p7_pc",   cmd_pc,             16'h0002);

    // Back-pressure: buffer fills to 2, requests stop, then drains in order
    do_reset(1'b0);
    tick(5);
    chk("t2_p5_req",  {15'd0, imem_req},  16'h0000);
    chk("t2_p5_vld",  {15'd0, cmd_valid}, 16'h0001);
    tick(5);
    chk("t2_p10_req", {15'd0, imem_req},  16'h0000);
    chk("t2_p10_cmd", COMMAND,            word(16'd0));
    chk("t2_p10_pc",  cmd_pc,             16'h0000);
    cmd_ready = 1'b1;
    tick(1);
    chk("t2_p11_cmd", COMMAND,            word(16'd1));
    chk("t2_p11_pc",  cmd_pc,             16'h0001);
    chk("t2_p11_req", {15'd0, imem_req},  16'h0001);
    chk("t2_p11_addr", imem_addr,         16'h0002);
    tick(1);
    chk("t2_p12_vld", {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t2_p13_pc",  cmd_pc,             16'h0002);
    chk("t2_p13_cmd", COMMAND,            word(16'd2));

    // Redirect in WAIT with slow response: stale word must be dropped
    do_reset(1'b1);
    rv_delay = 3;
    tick(2);
    chk("t3_p2_req",  {15'd0, imem_req},  16'h0000);
    PC_load = 1'b1; pc_target = 16'h0040;
    tick(1);
    PC_load = 1'b0;
    chk("t3_p3_req",  {15'd0, imem_req},  16'h0000);
    chk("t3_p3_vld",  {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t3_p4_vld",  {15'd0, cmd_valid}, 16'h0000);
    chk("t3_p4_req",  {15'd0, imem_req},  16'h0000);
    tick(1);
    chk("t3_p5_req",  {15'd0, imem_req},  16'h0001);
    chk("t3_p5_addr", imem_addr,          16'h0040);
    chk("t3_p5_vld",  {15'd0, cmd_valid}, 16'h0000);
    rv_delay = 1;
    tick(1);
    chk("t3_p6_vld",  {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t3_p7_cmd",  COMMAND,            word(16'h0040));
    chk("t3_p7_pc",   cmd_pc,             16'h0040);

    // Redirect coinciding with push and pop
    do_reset(1'b0);
    tick(4);
    chk("t4_p4_vld",  {15'd0, cmd_valid}, 16'h0001);
    chk("t4_p4_cmd",  COMMAND,            word(16'd0));
    cmd_ready = 1'b1; PC_load = 1'b1; pc_target = 16'h0080;
    tick(1);
    PC_load = 1'b0;
    chk("t4_p5_vld",  {15'd0, cmd_valid}, 16'h0000);
    chk("t4_p5_cmd",  COMMAND,            16'h0000);
    chk("t4_p5_req",  {15'd0, imem_req},  16'h0001);
    chk("t4_p5_addr", imem_addr,          16'h0080);
    tick(1);
    chk("t4_p6_vld",  {15'd0, cmd_valid}, 16'h0000);
    tick(1);
    chk("t4_p7_pc",   cmd_pc,             16'h0080);
    chk("t4_p7_cmd",  COMMAND,            word(16'h0080));

    // Word at address 3: HLT when detection is built in, ordinary otherwise
    do_reset(1'b1);
    tick(9);
    chk("t5_p9_pc",   cmd_pc,             16'h0003);
    chk("t5_p9_cmd",  COMMAND,            word(16'd3));
`ifdef IFU_HALT_DETECT_EN
    chk("t5_p9_halt", {15'd0, halted},    16'h0001);
    chk("t5_p9_req",  {15'd0, imem_req},  16'h0000);
    tick(3);
    chk("t5_p12_req",  {15'd0, imem_req}, 16'h0000);
    chk("t5_p12_halt", {15'd0, halted},   16'h0001);
    PC_load = 1'b1; pc_target = 16'h0010;
    tick(1);
    PC_load = 1'b0;
    chk("t5_p13_halt", {15'd0, halted},   16'h0000);
    chk("t5_p13_req",  {15'd0, imem_req}, 16'h0001);
    chk("t5_p13_addr", imem_addr,         16'h0010);
`else
    chk("t5_p9_halt", {15'd0, halted},    16'h0000);
    chk("t5_p9_req",  {15'd0, imem_req},  16'h0001);
    chk("t5_p9_addr", imem_addr,          16'h0004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
